tsp_sa: RTL and testbench

TSP_SA -- requirements
Module: tsp_sa

---
 rtl/tsp_sa.sv | 204 ++++++++++++++++++++
 tb/tb_tsp_sa.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsp_sa.sv
// tsp_sa: simulated-annealing solver for small symmetric TSP instances.
//
// A TSPLIB-like text description is streamed in one character per cycle.
// City lines ("index x y") are parsed into an on-chip table of up to 16
// cities; a line starting with 'E' (e.g. "EOF") ends loading once at least
// three cities are known. The block then anneals forever using random
// pairwise swaps of tour positions, reporting the shortest closed tour seen.
//
// Ports:
//   clk                 - sole clock, rising edge
//   rst                 - synchronous, active-high reset
//   specdata[7:0]       - ASCII character of the problem text (LF/CR = EOL)
//   has_specdata        - specdata is valid this cycle
//   ready_to_read       - block accepts a character this cycle (LOAD only)
//   rng[31:0]           - free-running random word from an external PRNG
//   best_distance[31:0] - shortest closed-tour length found so far
//   best_distance_valid - best_distance holds a real tour length
//   debug[7:0]          - {state[2:0], city_count[4:0]}
module tsp_sa (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  specdata,
    input  logic        has_specdata,
    output logic        ready_to_read,
    input  logic [31:0] rng,
    output logic [31:0] best_distance,
    output logic        best_distance_valid,
    output logic [7:0]  debug
);
    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        INIT    = 3'd1,
        PROPOSE = 3'd2,
        EVAL    = 3'd3,
        DECIDE  = 3'd4
    } state_t;

    state_t state, next_state;

    logic [15:0] cx [16];
    logic [15:0] cy [16];
    logic [3:0]  tour [16];
    logic [3:0]  cand [16];
    logic [4:0]  city_count;

    logic        line_start, city_line, in_field, in_frac;
    logic [1:0]  field;
    logic [15:0] px, py;

    logic [3:0]  k, k_next;
    logic [31:0] acc, current, cand_len;
    logic [15:0] temp;

    logic        take_char, is_eol, is_digit, is_space, end_line;
    logic        last_edge, prop_ok, accept_move;
    logic [3:0]  pi, pj, ca, cb;
    logic [15:0] dx, dy;
    logic [16:0] edge_len;
    logic        rng_unused;

    assign rng_unused = ^rng[15:8];

    assign take_char = has_specdata && ready_to_read;
    assign is_eol    = (specdata == 8'd10) || (specdata == 8'd13);
    assign is_digit  = (specdata >= "0") && (specdata <= "9");
    assign is_space  = (specdata == " ") || (specdata == 8'd9);
    assign end_line  = take_char && line_start && (specdata == "E") && (city_count >= 5'd3);

    assign last_edge = ({1'b0, k} == city_count - 5'd1);
    assign k_next    = last_edge ? 4'd0 : k + 4'd1;

    assign pi          = rng[3:0];
    assign pj          = rng[7:4];
    assign prop_ok     = ({1'b0, pi} < city_count) && ({1'b0, pj} < city_count) && (pi != pj);
    assign accept_move = (cand_len <= current) || (rng[31:16] < temp);

    // INIT and EVAL both walk the candidate tour; INIT loads it with the
    // identity order so one distance unit serves both.
    always_comb begin
        ca       = cand[k];
        cb       = cand[k_next];
        dx       = (cx[ca] >= cx[cb]) ? cx[ca] - cx[cb] : cx[cb] - cx[ca];
        dy       = (cy[ca] >= cy[cb]) ? cy[ca] - cy[cb] : cy[cb] - cy[ca];
        edge_len = {1'b0, dx} + {1'b0, dy};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (end_line)  next_state = INIT;
            INIT:    if (last_edge) next_state = PROPOSE;
            PROPOSE: if (prop_ok)   next_state = EVAL;
            EVAL:    if (last_edge) next_state = DECIDE;
            DECIDE:                 next_state = PROPOSE;
            default:                next_state = LOAD;
        endcase
    end

    always_comb begin
        ready_to_read = (state == LOAD) && !rst;
        debug         = {state, city_count};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            city_count          <= 5'd0;
            line_start          <= 1'b1;
            city_line           <= 1'b0;
            in_field            <= 1'b0;
            in_frac             <= 1'b0;
            field               <= 2'd0;
            px                  <= 16'd0;
            py                  <= 16'd0;
            k                   <= 4'd0;
            acc                 <= 32'd0;
            current             <= 32'd0;
            cand_len            <= 32'd0;
            temp                <= 16'hFFFF;
            best_distance       <= 32'd0;
            best_distance_valid <= 1'b0;
        end else begin
            case (state)
                LOAD: if (take_char) begin
                    if (is_eol) begin
                        // Lines past the 16th are parsed but never stored.
                        if (city_line && city_count < 5'd16) begin
                            cx[city_count[3:0]] <= px;
                            cy[city_count[3:0]] <= py;
                            city_count          <= city_count + 5'd1;
                        end
                        line_start <= 1'b1;
                        city_line  <= 1'b0;
                    end else if (line_start) begin
                        line_start <= 1'b0;
                        city_line  <= is_digit;
                        in_field   <= is_digit;
                        in_frac    <= 1'b0;
                        field      <= 2'd0;
                        px         <= 16'd0;
                        py         <= 16'd0;
                        if (end_line) begin
                            for (int i = 0; i < 16; i++) begin
                                tour[i] <= 4'(i);
                                cand[i] <= 4'(i);
                            end
                            k    <= 4'd0;
                            acc  <= 32'd0;
                            temp <= 16'hFFFF;
                        end
                    end else if (city_line) begin
                        if (is_space) begin
                            if (in_field && field != 2'd3) field <= field + 2'd1;
                            in_field <= 1'b0;
                            in_frac  <= 1'b0;
                        end else if (specdata == ".") begin
                            in_frac <= 1'b1;
                        end else if (is_digit) begin
                            in_field <= 1'b1;
                            // Low nibble of an ASCII digit is its value.
                            if (!in_frac && field == 2'd1) px <= px * 16'd10 + {12'd0, specdata[3:0]};
                            if (!in_frac && field == 2'd2) py <= py * 16'd10 + {12'd0, specdata[3:0]};
                        end
                    end
                end
                INIT, EVAL: begin
                    acc <= acc + {15'd0, edge_len};
                    k   <= k + 4'd1;
                    if (last_edge) begin
                        k   <= 4'd0;
                        acc <= 32'd0;
                        if (state == INIT) begin
                            current             <= acc + {15'd0, edge_len};
                            best_distance       <= acc + {15'd0, edge_len};
                            best_distance_valid <= 1'b1;
                        end else begin
                            cand_len <= acc + {15'd0, edge_len};
                        end
                    end
                end
                PROPOSE: if (prop_ok) begin
                    for (int i = 0; i < 16; i++) cand[i] <= tour[i];
                    cand[pi] <= tour[pj];
                    cand[pj] <= tour[pi];
                    k        <= 4'd0;
                    acc      <= 32'd0;
                end
                DECIDE: begin
                    if (accept_move) begin
                        for (int i = 0; i < 16; i++) tour[i] <= cand[i];
                        current <= cand_len;
                        if (cand_len < best_distance) best_distance <= cand_len;
                    end
                    if (temp != 16'd0) temp <= temp - 16'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tsp_sa.sv
// tb_tsp_sa: self-checking bench for tsp_sa. Problem text is streamed in as
// ASCII lines; expected tour lengths come from a coordinate table kept here
// and plain arithmetic over tours (input order, or brute force for the
// optimum of small random instances).
module tb_tsp_sa;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  specdata;
    logic        has_specdata;
    logic        ready_to_read;
    logic [31:0] rng;
    logic [31:0] best_distance;
    logic        best_distance_valid;
    logic [7:0]  debug;

    int testsRun    = 0;
    int testsFailed = 0;
    int mx [20];
    int my [20];
    int numCities   = 0;

    tsp_sa dut (
        .clk                 (clk),
        .rst                 (rst),
        .specdata            (specdata),
        .has_specdata        (has_specdata),
        .ready_to_read       (ready_to_read),
        .rng                 (rng),
        .best_distance       (best_distance),
        .best_distance_valid (best_distance_valid),
        .debug               (debug)
    );

    always #5 clk = ~clk;

    // Stand-in for the external free-running generator.
    initial begin
        rng = 32'd0;
        forever begin
            @(negedge clk);
            rng = $urandom();
        end
    end

    function automatic int unsigned manhattan(input int a, input int b);
        int ddx;
        int ddy;
        ddx = mx[a] - mx[b];
        ddy = my[a] - my[b];
        if (ddx < 0) ddx = -ddx;
        if (ddy < 0) ddy = -ddy;
        return ddx + ddy;
    endfunction

    function automatic int unsigned inputOrderLength(input int n);
        int unsigned len;
        len = 0;
        for (int i = 0; i < n; i++) len += manhattan(i, (i + 1) % n);
        return len;
    endfunction

    // Shortest closed tour by enumerating every index tuple and keeping permutations.
    function automatic int unsigned optimalLength(input int n);
        int unsigned best;
        int unsigned len;
        int total;
        int code;
        int perm [5];
        bit used [5];
        bit isPerm;
        best  = 32'hFFFF_FFFF;
        total = 1;
        for (int i = 0; i < n; i++) total *= n;
        for (int c = 0; c < total; c++) begin
            code   = c;
            isPerm = 1'b1;
            for (int i = 0; i < 5; i++) used[i] = 1'b0;
            for (int i = 0; i < n; i++) begin
                perm[i] = code % n;
                code    = code / n;
                if (used[perm[i]]) isPerm = 1'b0;
                used[perm[i]] = 1'b1;
            end
            if (isPerm) begin
                len = 0;
                for (int i = 0; i < n; i++) len += manhattan(perm[i], perm[(i + 1) % n]);
                if (len < best) best = len;
            end
        end
        return best;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic sendChar(input byte c);
        specdata     = c;
        has_specdata = 1'b1;
        @(posedge clk);
        #1;
        has_specdata = 1'b0;
    endtask

    task automatic applyStimulus(input string line, input bit crlf);
        for (int i = 0; i < line.len(); i++) sendChar(line[i]);
        if (crlf) sendChar(8'd13);
        sendChar(8'd10);
    endtask

    task automatic addCity(input int xv, input int yv, input bit frac, input bit crlf);
        string line;
        if (frac)
            line = $sformatf("%0d %0d.%0d %0d.%0d", numCities + 1, xv, $urandom_range(0, 99),
                             yv, $urandom_range(0, 999));
        else
            line = $sformatf("%0d %0d %0d", numCities + 1, xv, yv);
        mx[numCities] = xv % 65536;
        my[numCities] = yv % 65536;
        numCities++;
        applyStimulus(line, crlf);
    endtask

    task automatic doReset(input string tag);
        rst          = 1'b1;
        has_specdata = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput({tag, "_ready_in_rst"}, {31'd0, ready_to_read}, 32'd0);
        checkOutput({tag, "_best"}, best_distance, 32'd0);
        checkOutput({tag, "_valid"}, {31'd0, best_distance_valid}, 32'd0);
        checkOutput({tag, "_debug"}, {24'd0, debug}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, "_ready_after"}, {31'd0, ready_to_read}, 32'd1);
        numCities = 0;
    endtask

    task automatic waitValid(input int limit, input string tag);
        for (int c = 0; c < limit && !best_distance_valid; c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput(tag, {31'd0, best_distance_valid}, 32'd1);
    endtask

    task automatic runAnneal(input int limit, input logic [31:0] target, input bit stopAtTarget,
                             output bit mono);
        logic [31:0] prev;
        mono = 1'b1;
        for (int c = 0; c < limit; c++) begin
            if (stopAtTarget && best_distance == target) break;
            prev = best_distance;
            @(posedge clk);
            #1;
            if (best_distance > prev) mono = 1'b0;
        end
    endtask

    task automatic loadSquare();
        addCity(0, 0, 1'b0, 1'b0);
        addCity(0, 10, 1'b0, 1'b0);
        addCity(10, 10, 1'b0, 1'b0);
        addCity(10, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        bit mono;
        rst          = 1'b1;
        specdata     = 8'd0;
        has_specdata = 1'b0;

        doReset("por");

        // Square instance with headers; debug checked right after the 'E'.
        applyStimulus("NAME: sq", 1'b0);
        applyStimulus("DIMENSION: 4", 1'b1);
        applyStimulus("NODE_COORD_SECTION", 1'b0);
        loadSquare();
        sendChar("E");
        checkOutput("sq_debug_init", {24'd0, debug}, {24'd0, 3'd1, 5'd4});
        waitValid(5, "sq_valid");
        checkOutput("sq_initial", best_distance, 32'd40);
        runAnneal(400, 32'd40, 1'b0, mono);
        checkOutput("sq_stays", best_distance, 32'd40);
        checkOutput("sq_monotone", {31'd0, mono}, 32'd1);

        // Reset in the middle of annealing, then reload.
        doReset("anneal_rst");
        loadSquare();
        applyStimulus("EOF", 1'b0);
        waitValid(10, "reload_valid");
        checkOutput("reload_best", best_distance, 32'd40);

        // Crossed input order: 60 initially, annealer must find 40.
        doReset("cross");
        addCity(0, 0, 1'b0, 1'b0);
        addCity(10, 10, 1'b0, 1'b0);
        addCity(0, 10, 1'b0, 1'b0);
        addCity(10, 0, 1'b0, 1'b0);
        applyStimulus("EOF", 1'b0);
        waitValid(10, "cross_valid");
        checkOutput("cross_initial", best_distance, 32'd60);
        runAnneal(10000, 32'd40, 1'b1, mono);
        checkOutput("cross_final", best_distance, 32'd40);
        checkOutput("cross_monotone", {31'd0, mono}, 32'd1);

        // Fractional coordinates: (3,4), (7,1), (0,0) -> 7 + 7 + 8.
        doReset("float");
        applyStimulus("1 3.75 4.2", 1'b0);
        applyStimulus("2 7.9 1.0", 1'b0);
        applyStimulus("3 0 0", 1'b0);
        applyStimulus("EOF", 1'b0);
        waitValid(10, "float_valid");
        checkOutput("float_len", best_distance, 32'd22);

        // EOF with only two cities is ignored.
        doReset("short");
        applyStimulus("1 0 0", 1'b0);
        applyStimulus("2 4 0", 1'b0);
        applyStimulus("EOF", 1'b0);
        checkOutput("short_ready", {31'd0, ready_to_read}, 32'd1);
        checkOutput("short_debug", {24'd0, debug}, {24'd0, 3'd0, 5'd2});
        applyStimulus("3 5 5", 1'b0);
        applyStimulus("EOF", 1'b0);
        waitValid(10, "short_valid");
        checkOutput("short_len", best_distance, 32'd20);
        checkOutput("short_not_ready", {31'd0, ready_to_read}, 32'd0);

        // Reset in the middle of a city line.
        doReset("preload");
        applyStimulus("1 50 50", 1'b0);
        applyStimulus("2 70 20", 1'b0);
        sendChar("3");
        sendChar(" ");
        sendChar("5");
        doReset("load_rst");
        loadSquare();
        applyStimulus("EOF", 1'b0);
        waitValid(10, "load_rst_valid");
        checkOutput("load_rst_best", best_distance, 32'd40);

        // Twenty cities: only the first sixteen take part.
        doReset("twenty");
        for (int i = 0; i < 20; i++) addCity($urandom_range(0, 99999), $urandom_range(0, 99999), 1'b0, 1'b0);
        checkOutput("twenty_count", {27'd0, debug[4:0]}, 32'd16);
        applyStimulus("EOF", 1'b0);
        waitValid(20, "twenty_valid");
        checkOutput("twenty_initial", best_distance, inputOrderLength(16));

        // Random small instances, with fractions, CRLF and 16-bit wrap.
        for (int t = 0; t < 3; t++) begin
            doReset("rand");
            n = $urandom_range(3, 5);
            for (int i = 0; i < n; i++)
                addCity($urandom_range(0, 99999), $urandom_range(0, 99999), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
            applyStimulus("EOF", 1'b0);
            waitValid(10, "rand_valid");
            checkOutput("rand_initial", best_distance, inputOrderLength(n));
            runAnneal(15000, optimalLength(n), 1'b1, mono);
            checkOutput("rand_optimum", best_distance, optimalLength(n));
            checkOutput("rand_monotone", {31'd0, mono}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
